// File: rtl/execute_muldiv_unit.sv
// ----------------------------------------------------------------------------
// execute_muldiv_unit
//   Iterative RV32M multiply/divide unit for the Execute stage. One
//   multiply (shift-add) or divide (restoring) step per cycle, 32 steps per
//   operation. Divide-by-zero and signed overflow can optionally bypass the
//   iteration and finish the cycle after they are accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all state
//   StartE     M-extension op present in Execute (held while stalled)
//   MulDivOpE  funct3 of the M op
//   SrcAE      forwarded rs1
//   SrcBE      forwarded rs2
//   FlushE     abort any op in flight (not honoured in DONE)
//   BusyE      stall request to the hazard unit
//   DoneE      ResultE valid this cycle
//   ResultE    result, updated only on entry to DONE, held otherwise
// ----------------------------------------------------------------------------
module execute_muldiv_unit #(
  parameter int WIDTH         = 32,
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [2:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi_q;      // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;      // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q;    // multiplicand magnitude / divisor magnitude
  logic             neg_q;     // negate product or quotient
  logic             neg_rem_q; // remainder takes dividend sign
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;

  // Map the raw 64-bit product or the quotient/remainder pair to the
  // architectural result, restoring signs that were stripped on entry.
  function automatic logic [WIDTH-1:0] finalize(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic             neg,
    input logic             neg_rem
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    prod = {hi, lo};
    if (neg) prod = -prod;
    if (!op[2]) begin
      res = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (op[1]) begin
      res = neg_rem ? -hi : hi;
    end else begin
      res = neg ? -lo : lo;
    end
    return res;
  endfunction

  // Operand decode, evaluated while IDLE
  logic             is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div  = MulDivOpE[2];
    // Signed A: MUL, MULH, MULHSU, DIV, REM. Signed B: MUL, MULH, DIV, REM.
    a_sgn   = is_div ? ~MulDivOpE[0] : (MulDivOpE[1:0] != 2'b11);
    b_sgn   = is_div ? ~MulDivOpE[0] : ~MulDivOpE[1];
    a_neg   = a_sgn & SrcAE[WIDTH-1];
    b_neg   = b_sgn & SrcBE[WIDTH-1];
    a_mag   = a_neg ? -SrcAE : SrcAE;
    b_mag   = b_neg ? -SrcBE : SrcBE;
    b_zero  = (SrcBE == '0);
    ovf     = is_div & ~MulDivOpE[0] &
              (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
    special = is_div & (b_zero | ovf);
    if (b_zero) special_res = MulDivOpE[1] ? SrcAE : '1;
    else        special_res = MulDivOpE[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One iteration step
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             last;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!op_q[2]) begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      // Partial remainder always stays below the divisor, so a clear top bit
      // of the trial difference means "divisor fits".
      hi_nx = div_trial[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_nx = {lo_q[WIDTH-2:0], 1'b0};
    end
    last = (count_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and outputs
  always_comb begin
    state_d = state_q;
    BusyE   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE && !FlushE) begin
          BusyE   = 1'b1;
          state_d = (EARLY_SPECIAL && special) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        BusyE = 1'b1;
        if (FlushE)    state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (StartE && !FlushE) begin
            op_q      <= MulDivOpE;
            hi_q      <= '0;
            lo_q      <= is_div ? a_mag : b_mag;
            opnd_q    <= is_div ? b_mag : a_mag;
            // A zero divisor yields an all-ones quotient regardless of sign.
            neg_q     <= (a_neg ^ b_neg) & ~b_zero;
            neg_rem_q <= a_neg;
            count_q   <= '0;
            if (EARLY_SPECIAL && special) result_q <= special_res;
          end
        end
        S_RUN: begin
          if (!FlushE) begin
            hi_q    <= hi_nx;
            lo_q    <= lo_nx;
            count_q <= count_q + 1'b1;
            if (last) result_q <= finalize(op_q, hi_nx, lo_nx, neg_q, neg_rem_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign DoneE   = (state_q == S_DONE);
  assign ResultE = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int n_chk  = 0;
  int n_fail = 0;

  execute_muldiv_unit #(.WIDTH(32), .EARLY_SPECIAL(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StartE   (StartE),
    .MulDivOpE(MulDivOpE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .FlushE   (FlushE),
    .BusyE    (BusyE),
    .DoneE    (DoneE),
    .ResultE  (ResultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op starting at a negedge; returns at a negedge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    int          cyc, busy, exp_lat;
    logic [31:0] exp;
    exp     = ref_model(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    MulDivOpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
    if (DoneE) begin
      // still in DONE of previous op: unit must not restart here
      @(negedge clk);
      chk("done_single_pulse", {31'b0, DoneE}, 32'd0);
    end
    #1;
    busy = BusyE ? 1 : 0;
    cyc  = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin SrcAE = $urandom; SrcBE = $urandom; end
      if (DoneE) break;
      if (BusyE) busy++;
    end
    chk($sformatf("latency op%0d", op), cyc, exp_lat);
    chk($sformatf("busy_cycles op%0d", op), busy, exp_lat);
    chk($sformatf("result op%0d a=%08h b=%08h", op, a, b), ResultE, exp);
    if (!hold) begin
      StartE = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", {31'b0, DoneE}, 32'd0);
      chk("result_hold", ResultE, exp);
    end
  endtask

  initial begin
    logic [31:0] prev;
    int          dones;
    rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; MulDivOpE = '0; SrcAE = '0; SrcBE = '0;
    #12;
    chk("rst_busy", {31'b0, BusyE}, 32'd0);
    chk("rst_done", {31'b0, DoneE}, 32'd0);
    chk("rst_result", ResultE, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(3'd5, 32'd100,       32'd7,         1'b0);
    run_op(3'd7, 32'd100,       32'd7,         1'b0);
    run_op(3'd4, 32'd1234,      32'd0,         1'b0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0,         1'b0);
    run_op(3'd6, 32'd5,         32'd0,         1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // StartE held through DONE, immediate second op
    run_op(3'd0, 32'd12345,     32'd678,       1'b1);
    run_op(3'd4, 32'hFFFF_FF00, 32'd16,        1'b1);
    run_op(3'd6, 32'd9,         32'd0,         1'b1);
    run_op(3'd7, 32'd1000,      32'd33,        1'b0);

    // Flush in RUN
    prev = ResultE;
    MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5; StartE = 1'b1;
    repeat (10) @(negedge clk);
    FlushE = 1'b1; StartE = 1'b0;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_busy", {31'b0, BusyE}, 32'd0);
    chk("flush_done", {31'b0, DoneE}, 32'd0);
    chk("flush_result", ResultE, prev);
    dones = 0;
    repeat (40) begin @(negedge clk); if (DoneE) dones++; end
    chk("flush_no_done", dones, 32'd0);

    // Flush together with start in IDLE
    MulDivOpE = 3'd5; SrcAE = 32'd50; SrcBE = 32'd3; StartE = 1'b1; FlushE = 1'b1;
    #1 chk("flush_start_busy", {31'b0, BusyE}, 32'd0);
    @(negedge clk); StartE = 1'b0; FlushE = 1'b0;
    #1 chk("flush_start_ignored", {31'b0, BusyE}, 32'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (DoneE) dones++; end
    chk("flush_start_no_done", dones, 32'd0);
    chk("flush_start_result", ResultE, prev);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end
    StartE = 1'b0;
    @(negedge clk);

    // Make ResultE nonzero, then reset asynchronously mid-RUN
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    MulDivOpE = 3'd7; SrcAE = 32'd77; SrcBE = 32'd5; StartE = 1'b1;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0; StartE = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, BusyE}, 32'd0);
    chk("async_rst_done", {31'b0, DoneE}, 32'd0);
    chk("async_rst_result", ResultE, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(negedge clk); if (DoneE) dones++; end
    chk("rst_no_done", dones, 32'd0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
